// File: rtl/axi_rd_arbiter.sv
// Round-robin AR arbiter for MST_NUM read masters sharing one slave port.
// R beats are routed back in order by an FIFO recording {master, arlen}.
module axi_rd_arbiter #(
  parameter int MST_NUM    = 4,
  parameter int AXI_ID_W   = 4,
  parameter int AXI_DATA_W = 32,
  parameter int OSTD_NUM   = 4
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [MST_NUM-1:0]          m_arvalid,
  output logic [MST_NUM-1:0]          m_arready,
  input  logic [MST_NUM*AXI_ID_W-1:0] m_arid,
  input  logic [MST_NUM*4-1:0]        m_arlen,
  output logic                        s_arvalid,
  input  logic                        s_arready,
  output logic [AXI_ID_W-1:0]         s_arid,
  output logic [3:0]                  s_arlen,
  input  logic                        s_rvalid,
  output logic                        s_rready,
  input  logic [AXI_ID_W-1:0]         s_rid,
  input  logic [AXI_DATA_W-1:0]       s_rdata,
  input  logic [1:0]                  s_rresp,
  input  logic                        s_rlast,
  output logic [MST_NUM-1:0]          m_rvalid,
  input  logic [MST_NUM-1:0]          m_rready,
  output logic [AXI_ID_W-1:0]         m_rid,
  output logic [AXI_DATA_W-1:0]       m_rdata,
  output logic [1:0]                  m_rresp,
  output logic                        m_rlast,
  output logic                        ostd_full,
  output logic                        err_rlast
);

  localparam int          MW    = $clog2(MST_NUM);
  localparam int          PW    = $clog2(OSTD_NUM);
  localparam int unsigned NMST  = MST_NUM;
  localparam int unsigned DEPTH = OSTD_NUM;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   gnt_q, gnt_d;
  logic [MW-1:0]   last_q, last_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic [3:0]      beat_cnt_q, beat_cnt_d;
  logic            err_q, err_d;
  logic [MW-1:0]   fifo_mst_q [OSTD_NUM];
  logic [MW-1:0]   fifo_mst_d [OSTD_NUM];
  logic [3:0]      fifo_len_q [OSTD_NUM];
  logic [3:0]      fifo_len_d [OSTD_NUM];

  logic            push;
  logic            pop;
  logic            beat;
  logic            found;
  int unsigned     idx;
  logic [MW-1:0]   head_mst;
  logic [3:0]      head_len;

  assign ostd_full = (cnt_q == (PW+1)'(OSTD_NUM));
  assign err_rlast = err_q;

  assign m_rid   = s_rid;
  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;
  assign m_rlast = s_rlast;

  // Arbitration and grant FSM: search starts one past the last granted master.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    push    = 1'b0;
    found   = 1'b0;
    idx     = 0;
    case (state_q)
      IDLE: begin
        if ((|m_arvalid) && !ostd_full) begin
          for (int unsigned i = 1; i <= NMST; i++) begin
            idx = (32'(last_q) + i) % NMST;
            if (!found && m_arvalid[MW'(idx)]) begin
              found = 1'b1;
              gnt_d = MW'(idx);
            end
          end
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (s_arready) begin
          push    = 1'b1;
          last_d  = gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_arready = '0;
    s_arvalid = (state_q == HOLD);
    s_arid    = m_arid[gnt_q*AXI_ID_W +: AXI_ID_W];
    s_arlen   = m_arlen[gnt_q*4 +: 4];
    if (state_q == HOLD) begin
      m_arready[gnt_q] = s_arready;
    end
  end

  // R routing to the FIFO head, plus order FIFO and burst-length checking.
  always_comb begin
    head_mst   = fifo_mst_q[rd_ptr_q];
    head_len   = fifo_len_q[rd_ptr_q];
    m_rvalid   = '0;
    s_rready   = 1'b0;
    if (cnt_q != '0) begin
      m_rvalid[head_mst] = s_rvalid;
      s_rready           = m_rready[head_mst];
    end
    beat = s_rvalid && s_rready;
    pop  = beat && s_rlast;

    fifo_mst_d = fifo_mst_q;
    fifo_len_d = fifo_len_q;
    if (push) begin
      fifo_mst_d[wr_ptr_q] = gnt_q;
      fifo_len_d[wr_ptr_q] = s_arlen;
    end
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    beat_cnt_d = beat_cnt_q;
    if (pop) begin
      beat_cnt_d = '0;
    end else if (beat) begin
      beat_cnt_d = beat_cnt_q + 4'd1;
    end

    err_d = err_q;
    if (beat && ((s_rlast && (beat_cnt_q != head_len)) ||
                 (!s_rlast && (beat_cnt_q == head_len)))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      last_q     <= MW'(MST_NUM - 1);
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_mst_q[i] <= '0;
        fifo_len_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      fifo_mst_q <= fifo_mst_d;
      fifo_len_q <= fifo_len_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: reference model of grant order,
// outstanding order, R routing and rlast checking, with random traffic.
module tb_axi_rd_arbiter;

  localparam int MST  = 4;
  localparam int IDW  = 4;
  localparam int DW   = 32;
  localparam int OSTD = 4;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [MST-1:0]    m_arvalid;
  logic [MST-1:0]    m_arready;
  logic [MST*IDW-1:0] m_arid;
  logic [MST*4-1:0]  m_arlen;
  logic              s_arvalid;
  logic              s_arready;
  logic [IDW-1:0]    s_arid;
  logic [3:0]        s_arlen;
  logic              s_rvalid;
  logic              s_rready;
  logic [IDW-1:0]    s_rid;
  logic [DW-1:0]     s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rlast;
  logic [MST-1:0]    m_rvalid;
  logic [MST-1:0]    m_rready;
  logic [IDW-1:0]    m_rid;
  logic [DW-1:0]     m_rdata;
  logic [1:0]        m_rresp;
  logic              m_rlast;
  logic              ostd_full;
  logic              err_rlast;

  axi_rd_arbiter #(
    .MST_NUM(MST), .AXI_ID_W(IDW), .AXI_DATA_W(DW), .OSTD_NUM(OSTD)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_arlen(m_arlen),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast),
    .ostd_full(ostd_full), .err_rlast(err_rlast)
  );

  always #5 aclk = ~aclk;

  typedef struct { int m; int len; } ord_t;
  typedef struct { logic [IDW-1:0] id; int len; } sreq_t;

  int errors = 0;
  int checks = 0;

  // stimulus controls
  bit rand_en = 0, slave_en = 0, err_mode = 0, ar_rand = 0, rr_rand = 0, ar_fix = 1;
  int pend [MST];
  int lenc [MST];
  logic [IDW-1:0] arid_v [MST];
  logic [3:0]     arlen_v [MST];
  bit [MST-1:0]   ar_done;
  bit             rv_acc;
  sreq_t          slv_q [$];

  // reference model
  ord_t mq [$];
  int   exp_gnt [$];
  int   grant_log [$];
  int   beats_to [MST];
  bit   m_hold;
  int   m_gnt, m_last, m_beat;
  bit   m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    exp_gnt.delete();
    slv_q.delete();
    m_hold  = 0;
    m_gnt   = 0;
    m_last  = MST - 1;
    m_beat  = 0;
    m_err   = 0;
    rv_acc  = 0;
    ar_done = '0;
  endtask

  // master AR drivers, slave AR ready and master R ready
  initial begin
    m_arvalid = '0; m_arid = '0; m_arlen = '0; s_arready = 1'b0; m_rready = '0;
    forever begin
      @(posedge aclk); #1;
      if (!aresetn) begin
        m_arvalid = '0;
        for (int i = 0; i < MST; i++) pend[i] = 0;
      end else begin
        s_arready = ar_rand ? 1'($urandom_range(0, 1)) : ar_fix;
        m_rready  = rr_rand ? MST'($urandom) : '1;
        for (int i = 0; i < MST; i++) begin
          if (ar_done[i]) begin
            m_arvalid[i] = 1'b0;
            ar_done[i]   = 1'b0;
          end
          if (!m_arvalid[i] && (pend[i] > 0 || (rand_en && $urandom_range(0, 3) == 0))) begin
            if (pend[i] > 0) pend[i]--;
            arid_v[i]  = IDW'($urandom);
            arlen_v[i] = (lenc[i] >= 0) ? 4'(lenc[i]) : 4'($urandom_range(0, 3));
            m_arid[i*IDW +: IDW] = arid_v[i];
            m_arlen[i*4 +: 4]    = arlen_v[i];
            m_arvalid[i] = 1'b1;
          end
        end
      end
    end
  end

  // in-order slave responder
  initial begin
    int rb;
    rb = 0;
    s_rvalid = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0;
    forever begin
      @(posedge aclk); #1;
      if (!aresetn) begin
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        rb       = 0;
      end else begin
        if (rv_acc) begin
          rv_acc = 0;
          if (s_rlast) begin
            if (slv_q.size() > 0) void'(slv_q.pop_front());
            rb = 0;
          end else begin
            rb++;
          end
          s_rvalid = 1'b0;
        end
        if (!s_rvalid && slave_en && slv_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          s_rvalid = 1'b1;
          s_rid    = slv_q[0].id;
          s_rdata  = $urandom;
          s_rresp  = 2'($urandom_range(0, 3));
          s_rlast  = (rb == slv_q[0].len) || (err_mode && slv_q[0].len >= 1 && rb == 0);
        end
      end
    end
  end

  // monitor: compare DUT against the model, then advance the model to the next edge
  always @(negedge aclk) begin : mon
    int w, h, best, bestd, d;
    logic [MST-1:0] exp_rv;
    bit exp_rr, pop;
    if (!aresetn) begin
      model_reset();
    end else begin
      if (s_arvalid && s_arready) begin
        w = -1;
        for (int i = 0; i < MST; i++) if (m_arready[i]) w = i;
        grant_log.push_back(w);
        if (exp_gnt.size() == 0) begin
          chk("ar_unexpected", 1, 0);
        end else begin
          w = exp_gnt.pop_front();
          chk("ar_ready", 64'(m_arready), 64'(1) << w);
          chk("ar_id", 64'(s_arid), 64'(arid_v[w]));
          chk("ar_len", 64'(s_arlen), 64'(arlen_v[w]));
        end
        slv_q.push_back('{id: s_arid, len: int'(s_arlen)});
      end
      for (int i = 0; i < MST; i++) begin
        if (m_arvalid[i] && m_arready[i]) ar_done[i] = 1'b1;
        if (m_rvalid[i] && m_rready[i]) beats_to[i]++;
      end
      chk("s_arvalid", 64'(s_arvalid), 64'(m_hold));
      if (!m_hold) chk("arready_idle", 64'(m_arready), 0);
      chk("ostd_full", 64'(ostd_full), 64'(mq.size() == OSTD));

      exp_rv = '0;
      exp_rr = 0;
      if (mq.size() > 0) begin
        h = mq[0].m;
        exp_rv[h] = s_rvalid;
        exp_rr = m_rready[h];
      end
      chk("m_rvalid", 64'(m_rvalid), 64'(exp_rv));
      chk("s_rready", 64'(s_rready), 64'(exp_rr));
      if (s_rvalid) chk("r_fields", {25'd0, m_rid, m_rdata, m_rresp, m_rlast},
                        {25'd0, s_rid, s_rdata, s_rresp, s_rlast});
      chk("err_rlast", 64'(err_rlast), 64'(m_err));
      rv_acc = s_rvalid && s_rready;

      pop = 0;
      if (s_rvalid && exp_rr) begin
        if (s_rlast) begin
          if (m_beat != mq[0].len) m_err = 1;
          m_beat = 0;
          pop = 1;
        end else begin
          if (m_beat == mq[0].len) m_err = 1;
          m_beat = (m_beat + 1) % 16;
        end
      end
      if (m_hold) begin
        if (s_arready) begin
          mq.push_back('{m: m_gnt, len: int'(arlen_v[m_gnt])});
          m_last = m_gnt;
          m_hold = 0;
        end
      end else if (m_arvalid != '0 && mq.size() < OSTD) begin
        // nearest requester strictly after the last grant, cyclically
        best = -1;
        bestd = MST;
        for (int i = 0; i < MST; i++) begin
          d = (i - m_last - 1 + 2 * MST) % MST;
          if (m_arvalid[i] && d < bestd) begin
            bestd = d;
            best = i;
          end
        end
        m_gnt = best;
        m_hold = 1;
        exp_gnt.push_back(best);
      end
      if (pop) void'(mq.pop_front());
    end
  end

  function automatic bit quiet();
    int s;
    s = 0;
    for (int i = 0; i < MST; i++) s += pend[i];
    return mq.size() == 0 && !m_hold && m_arvalid == '0 && s == 0 &&
           slv_q.size() == 0 && !s_rvalid;
  endfunction

  task automatic wait_drain(input string tag, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(posedge aclk); #2;
      if (quiet()) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: drain timeout after %0d cycles", tag, budget);
  endtask

  initial begin
    for (int i = 0; i < MST; i++) begin
      pend[i] = 0; lenc[i] = -1; arid_v[i] = '0; arlen_v[i] = '0; beats_to[i] = 0;
    end
    model_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #2;
    chk("rst_s_arvalid", 64'(s_arvalid), 0);
    chk("rst_m_arready", 64'(m_arready), 0);
    chk("rst_s_rready", 64'(s_rready), 0);
    chk("rst_m_rvalid", 64'(m_rvalid), 0);
    chk("rst_ostd_full", 64'(ostd_full), 0);
    chk("rst_err_rlast", 64'(err_rlast), 0);
    aresetn = 1'b1;

    // all four request together
    ar_fix = 1; slave_en = 1; grant_log.delete();
    for (int i = 0; i < MST; i++) begin pend[i] = 1; lenc[i] = 0; end
    wait_drain("all4", 200);
    chk("all4_n", 64'(grant_log.size()), 4);
    for (int i = 0; i < grant_log.size() && i < 4; i++) chk("all4_order", 64'(grant_log[i]), 64'(i));

    // single master, four-beat burst
    grant_log.delete();
    for (int i = 0; i < MST; i++) beats_to[i] = 0;
    pend[2] = 1; lenc[2] = 3;
    wait_drain("m2_burst", 200);
    chk("m2_beats", 64'(beats_to[2]), 4);
    chk("m2_other_beats", 64'(beats_to[0] + beats_to[1] + beats_to[3]), 0);
    chk("m2_err", 64'(err_rlast), 0);

    // fill to OSTD_NUM with no R traffic; fifth request must wait
    slave_en = 0; grant_log.delete();
    for (int i = 0; i < MST; i++) lenc[i] = 1;
    pend = '{2, 1, 1, 1};
    repeat (30) @(posedge aclk);
    #2;
    chk("full_flag", 64'(ostd_full), 1);
    chk("full_arready", 64'(m_arready), 0);
    chk("full_arvalid", 64'(s_arvalid), 0);
    chk("full_n", 64'(grant_log.size()), 4);
    slave_en = 1;
    wait_drain("full_drain", 400);
    chk("full_n5", 64'(grant_log.size()), 5);
    if (grant_log.size() == 5) chk("full_5th", 64'(grant_log[4]), 0);
    for (int i = 0; i < MST; i++) lenc[i] = -1;

    // random traffic
    rand_en = 1; ar_rand = 1; rr_rand = 1;
    repeat (3000) @(posedge aclk);
    #2;
    rand_en = 0;
    wait_drain("rand_drain", 3000);
    ar_rand = 0; rr_rand = 0; ar_fix = 1;

    // rlast too early
    err_mode = 1; pend[1] = 1; lenc[1] = 1;
    wait_drain("err_burst", 200);
    err_mode = 0;
    chk("err_set", 64'(err_rlast), 1);
    pend[3] = 1; lenc[3] = 2;
    wait_drain("err_after", 200);
    chk("err_sticky", 64'(err_rlast), 1);
    lenc[1] = 3; lenc[3] = 3;

    // reset with two reads outstanding
    slave_en = 0; pend[0] = 1; lenc[0] = 3; pend[2] = 1; lenc[2] = 3;
    for (int n = 0; n < 100 && !(mq.size() == 2 && !m_hold); n++) begin
      @(posedge aclk); #2;
    end
    chk("rst2_outstanding", 64'(mq.size()), 2);
    slave_en = 1;
    repeat (2) @(posedge aclk);
    #3;
    aresetn = 1'b0;
    #1;
    chk("rst2_s_arvalid", 64'(s_arvalid), 0);
    chk("rst2_m_arready", 64'(m_arready), 0);
    chk("rst2_s_rready", 64'(s_rready), 0);
    chk("rst2_m_rvalid", 64'(m_rvalid), 0);
    chk("rst2_ostd_full", 64'(ostd_full), 0);
    chk("rst2_err_rlast", 64'(err_rlast), 0);
    repeat (2) @(posedge aclk);
    #2;
    aresetn = 1'b1;
    grant_log.delete();
    pend[3] = 1; pend[1] = 1;
    wait_drain("rst2_drain", 300);
    chk("rst2_n", 64'(grant_log.size()), 2);
    if (grant_log.size() == 2) begin
      chk("rst2_first", 64'(grant_log[0]), 1);
      chk("rst2_second", 64'(grant_log[1]), 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
